// File: rtl/pattern_note_sequencer.sv
// Purpose: steps through a small note/length pattern memory, emitting a phase delta and an attack/decay envelope per note.
// Latency: a start, stop, or note boundary shows on the outputs one cycle after the edge that sampled it. o_phase_delta and o_envelope are combinational from registered state.
// Backpressure: none. Pulses are single-cycle strobes, and pattern writes are accepted every cycle in any state.
// Ports: i_clk/i_rst_n clock and async active-low reset.
//        i_wr_* write one pattern entry.
//        i_start/i_stop control playback; stop has priority.
//        i_loop_end/i_loop_en select the last played entry and whether playback wraps.
//        i_env_level/i_env_hold set the attack shape and are sampled when a note loads.
//        o_busy, o_note_start, o_index, o_done report sequencer status.
//        o_top/o_top_valid carry the PWM top value.
//        o_phase_delta, o_envelope drive the synthesiser.
module pattern_note_sequencer #(
    parameter int         DEPTH           = 16,
    parameter int         CLOCKS_PER_TICK = 415_667,
    parameter logic [5:0] REST_NOTE       = 6'd0,
    parameter bit         RAW_LEN         = 1'b0,
    parameter logic [7:0] TOP             = 8'hff
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [5:0]               i_wr_note,
    input  logic [4:0]               i_wr_len,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic [$clog2(DEPTH)-1:0] i_loop_end,
    input  logic                     i_loop_en,
    input  logic [8:0]               i_env_level,
    input  logic [3:0]               i_env_hold,
    output logic                     o_busy,
    output logic                     o_note_start,
    output logic [$clog2(DEPTH)-1:0] o_index,
    output logic                     o_done,
    output logic [7:0]               o_top,
    output logic                     o_top_valid,
    output logic [31:0]              o_phase_delta,
    output logic [8:0]               o_envelope
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;

    typedef enum logic { IDLE, PLAY } state_t;
    typedef enum logic [1:0] { ENV_HOLD, ENV_DECAY, ENV_OFF } env_t;

    // Equal-tempered phase increments. Note 1 is the lowest C, and each group of 12 codes is one octave higher.
    function automatic logic [31:0] note_table(input logic [5:0] n);
        logic [5:0]  k;
        logic [31:0] base;
        k = n - 6'd1;
        case (k % 6'd12)
            6'd0:    base = 32'd1_000_000;
            6'd1:    base = 32'd1_059_463;
            6'd2:    base = 32'd1_122_462;
            6'd3:    base = 32'd1_189_207;
            6'd4:    base = 32'd1_259_921;
            6'd5:    base = 32'd1_334_840;
            6'd6:    base = 32'd1_414_214;
            6'd7:    base = 32'd1_498_307;
            6'd8:    base = 32'd1_587_401;
            6'd9:    base = 32'd1_681_793;
            6'd10:   base = 32'd1_781_797;
            default: base = 32'd1_887_749;
        endcase
        if (n == REST_NOTE) note_table = 32'd0;
        else                note_table = base << (k / 6'd12);
    endfunction

    // A length code counts envelope ticks.
    function automatic logic [31:0] note_length_table(input logic [4:0] len);
        note_length_table = 32'(len) * 32'(CLOCKS_PER_TICK);
    endfunction

    logic [10:0]   mem [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] index_q;
    logic [5:0]    note_q;
    logic [4:0]    len_q;
    logic [31:0]   dur_cnt;
    logic [TW-1:0] tick_cnt;
    logic [8:0]    level_q;
    logic [3:0]    hold_left;
    env_t          env_phase;
    logic          note_start_q, done_q, top_valid_q;

    logic [31:0]   dur_raw, dur;
    logic          note_last, at_end, do_start, do_adv, load, finish, tick_end;
    logic [AW-1:0] load_idx;

    // Pattern memory has no reset, and its contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= {i_wr_note, i_wr_len};
    end

    always_comb begin
        dur_raw   = RAW_LEN ? {27'd0, len_q} : note_length_table(len_q);
        dur       = (dur_raw == 32'd0) ? 32'd1 : dur_raw;
        note_last = (dur_cnt == dur - 32'd1);
        at_end    = (index_q == i_loop_end) || (index_q == AW'(DEPTH - 1));
        do_start  = i_start && !i_stop;
        do_adv    = (state_q == PLAY) && !i_stop && !i_start && note_last;
        load      = do_start || (do_adv && (!at_end || i_loop_en));
        finish    = do_adv && at_end && !i_loop_en;
        load_idx  = (do_start || at_end) ? '0 : index_q + 1'b1;
        tick_end  = (tick_cnt == TW'(CLOCKS_PER_TICK - 1));
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: stop beats start, and start beats the end of a pass.
    always_comb begin
        state_d = state_q;
        if (i_stop)        state_d = IDLE;
        else if (do_start) state_d = PLAY;
        else if (finish)   state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        o_busy     = (state_q == PLAY);
        o_envelope = 9'd0;
        if (state_q == PLAY && note_q != REST_NOTE) begin
            case (env_phase)
                ENV_HOLD:  o_envelope = level_q;
                ENV_DECAY: o_envelope = level_q >> 2;
                default:   o_envelope = 9'd0;
            endcase
        end
    end

    // Note, duration, and envelope datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            index_q      <= '0;
            note_q       <= REST_NOTE;
            len_q        <= 5'd0;
            dur_cnt      <= 32'd0;
            tick_cnt     <= '0;
            level_q      <= 9'd0;
            hold_left    <= 4'd0;
            env_phase    <= ENV_OFF;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
            top_valid_q  <= 1'b0;
        end else begin
            note_start_q <= load;
            done_q       <= finish;
            top_valid_q  <= 1'b1;
            if (load) begin
                index_q         <= load_idx;
                {note_q, len_q} <= mem[load_idx];
                dur_cnt         <= 32'd0;
                tick_cnt        <= '0;
                level_q         <= i_env_level;
                hold_left       <= i_env_hold;
                env_phase       <= (i_env_hold == 4'd0) ? ENV_DECAY : ENV_HOLD;
            end else if (i_stop || finish) begin
                note_q <= REST_NOTE;
            end else if (state_q == PLAY) begin
                dur_cnt <= dur_cnt + 32'd1;
                if (tick_end) begin
                    tick_cnt <= '0;
                    // Hold lasts exactly hold_left ticks, and decay lasts exactly one tick.
                    if (env_phase == ENV_HOLD) begin
                        if (hold_left == 4'd1) env_phase <= ENV_DECAY;
                        else                   hold_left <= hold_left - 4'd1;
                    end else if (env_phase == ENV_DECAY) begin
                        env_phase <= ENV_OFF;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    assign o_note_start  = note_start_q;
    assign o_done        = done_q;
    assign o_index       = index_q;
    assign o_top         = TOP;
    assign o_top_valid   = top_valid_q;
    assign o_phase_delta = note_table(note_q);

endmodule

// File: tb/tb_pattern_note_sequencer.sv
module tb_pattern_note_sequencer;

    localparam int DEPTH = 4;
    localparam int CPT   = 4;

    logic        clk, rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [5:0]  wr_note;
    logic [4:0]  wr_len;
    logic        start, stop;
    logic [1:0]  loop_end;
    logic        loop_en;
    logic [8:0]  env_level;
    logic [3:0]  env_hold;
    logic        busy, note_start, done, top_valid;
    logic [1:0]  index;
    logic [7:0]  top;
    logic [31:0] phase_delta;
    logic [8:0]  envelope;

    pattern_note_sequencer #(
        .DEPTH(DEPTH), .CLOCKS_PER_TICK(CPT), .REST_NOTE(6'd0), .RAW_LEN(1'b1), .TOP(8'hff)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_note(wr_note), .i_wr_len(wr_len),
        .i_start(start), .i_stop(stop), .i_loop_end(loop_end), .i_loop_en(loop_en),
        .i_env_level(env_level), .i_env_hold(env_hold),
        .o_busy(busy), .o_note_start(note_start), .o_index(index), .o_done(done),
        .o_top(top), .o_top_valid(top_valid), .o_phase_delta(phase_delta), .o_envelope(envelope)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: a note is (entry, cycles elapsed) and the envelope is a function of elapsed time.
    int m_note_mem [DEPTH];
    int m_len_mem  [DEPTH];
    int m_busy, m_idx, m_note, m_len, m_t, m_lvl, m_hold, m_ns, m_done, m_tv;

    function automatic logic [31:0] ref_phase(int n);
        int semi, oct, base;
        if (n == 0) return 32'd0;
        semi = (n - 1) % 12;
        oct  = (n - 1) / 12;
        base = $rtoi(1.0e6 * $pow(2.0, semi / 12.0) + 0.5);
        return 32'(base) << oct;
    endfunction

    function automatic int ref_env();
        if (m_busy == 0 || m_note == 0) return 0;
        if (m_t < m_hold * CPT)       return m_lvl;
        if (m_t < (m_hold + 1) * CPT) return m_lvl / 4;
        return 0;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_idx = 0; m_note = 0; m_len = 0; m_t = 0;
        m_lvl = 0; m_hold = 0; m_ns = 0; m_done = 0; m_tv = 0;
    endtask

    task automatic m_load(int i);
        m_idx  = i;
        m_note = m_note_mem[i];
        m_len  = m_len_mem[i];
        m_t    = 0;
        m_lvl  = int'(env_level);
        m_hold = int'(env_hold);
        m_ns   = 1;
        m_busy = 1;
    endtask

    // Advance the model by one clock edge using the inputs that were stable before that edge.
    task automatic m_step();
        int d;
        m_ns = 0; m_done = 0; m_tv = 1;
        d = (m_len == 0) ? 1 : m_len;
        if (stop) begin
            m_busy = 0; m_note = 0;
        end else if (start) begin
            m_load(0);
        end else if (m_busy != 0) begin
            if (m_t == d - 1) begin
                if (m_idx == int'(loop_end) || m_idx == DEPTH - 1) begin
                    if (loop_en) m_load(0);
                    else begin m_busy = 0; m_note = 0; m_done = 1; end
                end else begin
                    m_load(m_idx + 1);
                end
            end else begin
                m_t++;
            end
        end
        if (wr_en) begin
            m_note_mem[wr_addr] = int'(wr_note);
            m_len_mem[wr_addr]  = int'(wr_len);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("busy",       32'(busy),       32'(m_busy));
        check("note_start", 32'(note_start), 32'(m_ns));
        check("index",      32'(index),      32'(m_idx));
        check("done",       32'(done),       32'(m_done));
        check("top",        32'(top),        32'hff);
        check("top_valid",  32'(top_valid),  32'(m_tv));
        check("phase",      phase_delta,     ref_phase(m_note));
        check("envelope",   32'(envelope),   32'(ref_env()));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(int a, int n, int l);
        wr_en = 1'b1; wr_addr = 2'(a); wr_note = 6'(n); wr_len = 5'(l);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic       busy;
        logic       ns;
        logic [1:0] idx;
        logic       done;
    } vec_t;

    function automatic vec_t mk(logic s, logic p, logic b, logic n, logic [1:0] i, logic d);
        vec_t v;
        v.start = s; v.stop = p; v.busy = b; v.ns = n; v.idx = i; v.done = d;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        int n;
        rst_n = 1'b1; wr_en = 0; wr_addr = 0; wr_note = 0; wr_len = 0;
        start = 0; stop = 0; loop_end = 2'd3; loop_en = 0; env_level = 9'd100; env_hold = 4'd1;
        m_reset();
        for (int i = 0; i < DEPTH; i++) begin m_note_mem[i] = 0; m_len_mem[i] = 0; end
        #2;
        do_reset();

        // Four notes of 3, 5, 2, and 4 cycles, no looping. Vector k is checked after edge k.
        vecs[0] = mk(1, 0, 1, 1, 0, 0);
        vecs[1] = mk(0, 0, 1, 0, 0, 0);
        vecs[2] = mk(0, 0, 1, 0, 0, 0);
        vecs[3] = mk(0, 0, 1, 1, 1, 0);
        for (int i = 4; i < 8; i++) vecs[i] = mk(0, 0, 1, 0, 1, 0);
        vecs[8]  = mk(0, 0, 1, 1, 2, 0);
        vecs[9]  = mk(0, 0, 1, 0, 2, 0);
        vecs[10] = mk(0, 0, 1, 1, 3, 0);
        for (int i = 11; i < 14; i++) vecs[i] = mk(0, 0, 1, 0, 3, 0);
        vecs[14] = mk(0, 0, 0, 0, 3, 1);
        vecs[15] = mk(0, 0, 0, 0, 3, 0);

        wr(0, 1, 3); wr(1, 13, 5); wr(2, 25, 2); wr(3, 0, 4);
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start; stop = vecs[i].stop;
            cyc();
            start = 0; stop = 0;
            check("s1_busy", 32'(busy),       32'(vecs[i].busy));
            check("s1_ns",   32'(note_start), 32'(vecs[i].ns));
            check("s1_idx",  32'(index),      32'(vecs[i].idx));
            check("s1_done", 32'(done),       32'(vecs[i].done));
        end

        // Looping: indices wrap 0..3 and done never fires.
        loop_en = 1; n = 0;
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 42; i++) begin
            if (i > 0) cyc();
            if (note_start) begin check("s2_idx", 32'(index), 32'(n % 4)); n++; end
            check("s2_done", 32'(done), 0);
        end
        check("s2_loads", 32'(n >= 12), 1);
        stop = 1; cyc(); stop = 0;

        // Envelope: hold 7 ticks at 14, then one tick at 14>>2. The 31-cycle note ends before decay finishes.
        loop_en = 0; loop_end = 0; env_level = 9'd14; env_hold = 4'd7;
        wr(0, 13, 31);
        start = 1; cyc(); start = 0;
        for (int t = 0; t < 31; t++) begin
            if (t > 0) cyc();
            check("s3_env", 32'(envelope), (t < 28) ? 32'd14 : 32'd3);
        end
        cyc();
        check("s3_env_idle", 32'(envelope), 0);
        check("s3_done", 32'(done), 1);

        // Start and stop together during play: stop wins and done stays low.
        loop_end = 3;
        start = 1; cyc(); start = 0;
        repeat (3) cyc();
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        check("s4_busy", 32'(busy), 0);
        check("s4_env",  32'(envelope), 0);
        check("s4_done", 32'(done), 0);
        cyc();
        check("s4_done2", 32'(done), 0);

        // Rewriting the playing entry takes effect only when it reloads.
        loop_end = 1; loop_en = 1; env_hold = 4'd2;
        wr(0, 5, 6); wr(1, 9, 2);
        start = 1; cyc(); start = 0;
        check("s5_phase0", phase_delta, ref_phase(5));
        for (int k = 1; k < 6; k++) begin
            if (k == 2) begin wr_en = 1; wr_addr = 0; wr_note = 6'd20; wr_len = 5'd6; end
            cyc();
            wr_en = 0;
            check("s5_phase_old", phase_delta, ref_phase(5));
        end
        for (int k = 0; k < 2; k++) begin cyc(); check("s5_phase_e1", phase_delta, ref_phase(9)); end
        cyc();
        check("s5_phase_new", phase_delta, ref_phase(20));
        check("s5_idx", 32'(index), 0);
        stop = 1; cyc(); stop = 0;

        // Reset mid-note clears the outputs without an edge. Afterwards a length-0 entry plays for one cycle.
        loop_en = 0;
        wr(0, 3, 2); wr(1, 7, 20);
        start = 1; cyc(); start = 0;
        repeat (4) cyc();
        check("s6_pre_idx", 32'(index), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_busy",  32'(busy), 0);
        check("s6_idx",   32'(index), 0);
        check("s6_env",   32'(envelope), 0);
        check("s6_tv",    32'(top_valid), 0);
        check("s6_phase", phase_delta, 0);
        check("s6_done",  32'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        loop_end = 0;
        wr(0, 3, 0);
        start = 1; cyc(); start = 0;
        check("s6_len0_busy", 32'(busy), 1);
        check("s6_len0_ns",   32'(note_start), 1);
        cyc();
        check("s6_len0_end",  32'(busy), 0);
        check("s6_len0_done", 32'(done), 1);

        // Random traffic compared against the reference model.
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 2'($urandom);
            wr_note = 6'($urandom);
            wr_len  = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            start   = busy ? (($urandom % 60) == 0) : (($urandom % 5) == 0);
            stop    = ($urandom % 97) == 0;
            if ($urandom % 50 == 0) begin loop_end = 2'($urandom); loop_en = 1'($urandom); end
            env_level = 9'($urandom);
            env_hold  = 4'($urandom_range(0, 3));
            cyc();
        end
        wr_en = 0; start = 0; stop = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
